// File: rtl/mesi_req_ctrl_pkg.sv
// Shared encodings for the MESI downstream request controller: line states,
// core/bus op and response codes, FSM states and the fill-state rule.
package mesi_req_ctrl_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  localparam logic [2:0] CDREQ_RD  = 3'd0;
  localparam logic [2:0] CDREQ_RFO = 3'd1;
  localparam logic [2:0] CDREQ_WB  = 3'd2;
  localparam logic [2:0] CDREQ_MD  = 3'd3;

  localparam logic [1:0] CURSP_OKAY  = 2'd0;
  localparam logic [1:0] CURSP_ERROR = 2'd1;

  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;
  localparam logic [2:0] SDREQ_WB  = 3'd3;

  localparam logic [2:0] SURSP_OKAY  = 3'd0;
  localparam logic [2:0] SURSP_FETCH = 3'd1;
  localparam logic [2:0] SURSP_SNOOP = 3'd2;
  localparam logic [2:0] SURSP_ERROR = 3'd3;

  typedef enum logic [2:0] {
    REQ_IDLE       = 3'd0,
    REQ_ALLOCATE   = 3'd1,
    REQ_INIT_SDREQ = 3'd2,
    REQ_WAIT_SURSP = 3'd3,
    REQ_RSP_CURSP  = 3'd4,
    REQ_EVICT      = 3'd5
  } req_state_t;

  // Line state after a successful fill or upgrade.
  function automatic mesi_t fill_state(logic [2:0] op, logic [2:0] rsp);
    if (op == CDREQ_MD) return MESI_M;
    if (op == CDREQ_RD && rsp == SURSP_SNOOP) return MESI_S;
    return MESI_E;
  endfunction

endpackage

// File: rtl/mesi_req_ctrl_if.sv
// Core-side and bus-side valid/ready channels of the MESI request controller.
interface mesi_req_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cdreq_valid;
  logic                  cdreq_ready;
  logic [2:0]            cdreq_op;
  logic [ADDR_WIDTH-1:0] cdreq_addr;
  logic [DATA_WIDTH-1:0] cdreq_data;

  logic                  cursp_valid;
  logic                  cursp_ready;
  logic [1:0]            cursp_rsp;
  logic [DATA_WIDTH-1:0] cursp_data;

  logic                  sdreq_valid;
  logic                  sdreq_ready;
  logic [2:0]            sdreq_op;
  logic [ADDR_WIDTH-1:0] sdreq_addr;
  logic [DATA_WIDTH-1:0] sdreq_data;

  logic                  sursp_valid;
  logic                  sursp_ready;
  logic [2:0]            sursp_rsp;
  logic [DATA_WIDTH-1:0] sursp_data;

  modport master (
    input  cdreq_valid, cdreq_op, cdreq_addr, cdreq_data,
    output cdreq_ready,
    output cursp_valid, cursp_rsp, cursp_data,
    input  cursp_ready,
    output sdreq_valid, sdreq_op, sdreq_addr, sdreq_data,
    input  sdreq_ready,
    input  sursp_valid, sursp_rsp, sursp_data,
    output sursp_ready
  );

  modport slave (
    output cdreq_valid, cdreq_op, cdreq_addr, cdreq_data,
    input  cdreq_ready,
    input  cursp_valid, cursp_rsp, cursp_data,
    output cursp_ready,
    input  sdreq_valid, sdreq_op, sdreq_addr, sdreq_data,
    output sdreq_ready,
    output sursp_valid, sursp_rsp, sursp_data,
    input  sursp_ready
  );
endinterface

// File: rtl/mesi_line_array.sv
// Direct-mapped tag/state/data storage: one combinational read port, one
// write port, whole array cleared by synchronous reset.
module mesi_line_array
  import mesi_req_ctrl_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int TAG_W      = 6,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  output mesi_t                 rd_state,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  mesi_t                 wr_state,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  typedef struct packed {
    mesi_t                 state;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  line_t mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= '{state: wr_state, tag: wr_tag, data: wr_data};
    end
  end

  assign rd_state = mem[rd_idx].state;
  assign rd_tag   = mem[rd_idx].tag;
  assign rd_data  = mem[rd_idx].data;
endmodule

// File: rtl/mesi_req_ctrl.sv
// MESI downstream request controller: core lookup, victim write-back, fill and
// S->M upgrade over the bus. Define REQ_TIMEOUT_EN to add a WAIT_SURSP watchdog.
module mesi_req_ctrl
  import mesi_req_ctrl_pkg::*;
#(
  parameter int NUM_LINES   = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input logic            clk,
  input logic            rst_n,
  mesi_req_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  req_state_t st, st_nxt;

  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            sd_op_q, sd_op_nxt;
  logic [ADDR_WIDTH-1:0] sd_addr_q, sd_addr_nxt;
  logic [DATA_WIDTH-1:0] sd_data_q, sd_data_nxt;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;
  logic                  err_q, err_nxt;
  logic                  evict_q, evict_nxt;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  mesi_t                 rd_state, wr_state;
  logic [TAG_W-1:0]      rd_tag, wr_tag;
  logic [DATA_WIDTH-1:0] rd_data, wr_data;
  logic                  wr_en, hit, sursp_hs, tmo;

  assign idx      = addr_q[IDX_W-1:0];
  assign tag      = addr_q[ADDR_WIDTH-1:IDX_W];
  assign hit      = (rd_state != MESI_I) && (rd_tag == tag);
  assign sursp_hs = bus.sursp_valid && (st == REQ_WAIT_SURSP);

  mesi_line_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_arr (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (idx),
    .rd_state(rd_state),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_state(wr_state),
    .wr_tag  (wr_tag),
    .wr_data (wr_data)
  );

`ifdef REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  // Held at zero outside WAIT_SURSP, so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_n || st != REQ_WAIT_SURSP) cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end
  assign tmo = (st == REQ_WAIT_SURSP) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) st <= REQ_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt      = st;
    sd_op_nxt   = sd_op_q;
    sd_addr_nxt = sd_addr_q;
    sd_data_nxt = sd_data_q;
    rdata_nxt   = rdata_q;
    err_nxt     = err_q;
    evict_nxt   = evict_q;
    wr_en       = 1'b0;
    wr_state    = rd_state;
    wr_tag      = rd_tag;
    wr_data     = rd_data;
    unique case (st)
      REQ_IDLE: begin
        if (bus.cdreq_valid) begin
          st_nxt    = REQ_ALLOCATE;
          err_nxt   = 1'b0;
          evict_nxt = 1'b0;
          rdata_nxt = '0;
        end
      end
      REQ_ALLOCATE: begin
        sd_addr_nxt = addr_q;
        sd_data_nxt = '0;
        st_nxt      = REQ_RSP_CURSP;
        if (op_q[2]) begin
          err_nxt = 1'b1;
        end else if (hit) begin
          if (op_q == CDREQ_RD) begin
            rdata_nxt = rd_data;
          end else if (op_q == CDREQ_WB) begin
            if (rd_state == MESI_M) begin
              sd_op_nxt   = SDREQ_WB;
              sd_data_nxt = rd_data;
              st_nxt      = REQ_INIT_SDREQ;
            end
          end else if (rd_state == MESI_S) begin
            sd_op_nxt = SDREQ_INV;
            st_nxt    = REQ_INIT_SDREQ;
          end else if (op_q == CDREQ_MD) begin
            wr_en    = 1'b1;
            wr_state = MESI_M;
            wr_data  = wdata_q;
          end else begin
            rdata_nxt = rd_data;
          end
        end else if (op_q != CDREQ_WB) begin
          sd_op_nxt = (op_q == CDREQ_RD) ? SDREQ_RD : SDREQ_RFO;
          st_nxt    = REQ_INIT_SDREQ;
          if (rd_state == MESI_M) begin
            evict_nxt   = 1'b1;
            sd_op_nxt   = SDREQ_WB;
            sd_addr_nxt = {rd_tag, idx};
            sd_data_nxt = rd_data;
            st_nxt      = REQ_EVICT;
          end
        end
      end
      REQ_EVICT, REQ_INIT_SDREQ: begin
        if (bus.sdreq_ready) st_nxt = REQ_WAIT_SURSP;
      end
      REQ_WAIT_SURSP: begin
        if (sursp_hs) begin
          wr_en = 1'b1;
          if (bus.sursp_rsp == SURSP_ERROR) begin
            err_nxt  = 1'b1;
            wr_state = MESI_I;
            wr_data  = '0;
            st_nxt   = REQ_RSP_CURSP;
          end else if (evict_q) begin
            // Victim is gone; the line stays INVALID until the fill lands.
            evict_nxt   = 1'b0;
            wr_state    = MESI_I;
            sd_op_nxt   = (op_q == CDREQ_RD) ? SDREQ_RD : SDREQ_RFO;
            sd_addr_nxt = addr_q;
            sd_data_nxt = '0;
            st_nxt      = REQ_INIT_SDREQ;
          end else if (sd_op_q == SDREQ_WB) begin
            wr_state = MESI_E;
            st_nxt   = REQ_RSP_CURSP;
          end else begin
            wr_tag   = tag;
            wr_state = fill_state(op_q, bus.sursp_rsp);
            if (op_q == CDREQ_MD)        wr_data = wdata_q;
            else if (sd_op_q != SDREQ_INV) wr_data = bus.sursp_data;
            rdata_nxt = (op_q == CDREQ_MD) ? '0 : wr_data;
            st_nxt    = REQ_RSP_CURSP;
          end
        end else if (tmo) begin
          err_nxt = 1'b1;
          st_nxt  = REQ_RSP_CURSP;
          if (!evict_q) begin
            wr_en    = 1'b1;
            wr_state = MESI_I;
            wr_data  = '0;
          end
        end
      end
      REQ_RSP_CURSP: begin
        if (bus.cursp_ready) st_nxt = REQ_IDLE;
      end
      default: st_nxt = REQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sd_op_q   <= '0;
      sd_addr_q <= '0;
      sd_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      evict_q   <= 1'b0;
    end else begin
      if (st == REQ_IDLE && bus.cdreq_valid) begin
        op_q    <= bus.cdreq_op;
        addr_q  <= bus.cdreq_addr;
        wdata_q <= bus.cdreq_data;
      end
      sd_op_q   <= sd_op_nxt;
      sd_addr_q <= sd_addr_nxt;
      sd_data_q <= sd_data_nxt;
      rdata_q   <= rdata_nxt;
      err_q     <= err_nxt;
      evict_q   <= evict_nxt;
    end
  end

  assign bus.cdreq_ready = (st == REQ_IDLE);
  assign bus.cursp_valid = (st == REQ_RSP_CURSP);
  assign bus.cursp_rsp   = !bus.cursp_valid ? CURSP_OKAY : (err_q ? CURSP_ERROR : CURSP_OKAY);
  assign bus.cursp_data  = (bus.cursp_valid && !err_q) ? rdata_q : '0;
  assign bus.sdreq_valid = (st == REQ_INIT_SDREQ) || (st == REQ_EVICT);
  assign bus.sdreq_op    = bus.sdreq_valid ? sd_op_q   : '0;
  assign bus.sdreq_addr  = bus.sdreq_valid ? sd_addr_q : '0;
  assign bus.sdreq_data  = bus.sdreq_valid ? sd_data_q : '0;
  assign bus.sursp_ready = (st == REQ_WAIT_SURSP);
endmodule

// File: tb/tb_mesi_req_ctrl.sv
// Directed bench for mesi_req_ctrl (4 lines, 8-bit address, 32-bit data):
// hits, fills, victim write-back, upgrades, errors, reset mid-flight, timeout.
module tb_mesi_req_ctrl;
  import mesi_req_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mesi_req_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  mesi_req_ctrl #(
    .NUM_LINES  (4),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line_state(input string tag, input int i, input mesi_t exp);
    chk(tag, 64'(dut.u_arr.mem[i].state), 64'(exp));
  endtask

  task automatic send_req(input string tag, input logic [2:0] op, input logic [7:0] addr,
                          input logic [31:0] data);
    chk({tag, "_cdreq_ready"}, 64'(bus.cdreq_ready), 64'd1);
    bus.cdreq_valid = 1'b1;
    bus.cdreq_op    = op;
    bus.cdreq_addr  = addr;
    bus.cdreq_data  = data;
    tick();
    bus.cdreq_valid = 1'b0;
    bus.cdreq_op    = '0;
    bus.cdreq_addr  = '0;
    bus.cdreq_data  = '0;
  endtask

  task automatic wait_sdvld(input string tag);
    int n = 0;
    while (!bus.sdreq_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_sdreq_valid"}, 64'(bus.sdreq_valid), 64'd1);
  endtask

  // Holds sdreq_ready low one cycle to check the request stays put.
  task automatic expect_sdreq(input string tag, input logic [2:0] op, input logic [7:0] addr,
                              input logic [31:0] data);
    wait_sdvld(tag);
    tick();
    chk({tag, "_sd_op"},   64'(bus.sdreq_op),   64'(op));
    chk({tag, "_sd_addr"}, 64'(bus.sdreq_addr), 64'(addr));
    chk({tag, "_sd_data"}, 64'(bus.sdreq_data), 64'(data));
    bus.sdreq_ready = 1'b1;
    tick();
    bus.sdreq_ready = 1'b0;
  endtask

  task automatic send_sursp(input string tag, input logic [2:0] rsp, input logic [31:0] data);
    chk({tag, "_sursp_ready"}, 64'(bus.sursp_ready), 64'd1);
    bus.sursp_valid = 1'b1;
    bus.sursp_rsp   = rsp;
    bus.sursp_data  = data;
    tick();
    bus.sursp_valid = 1'b0;
    bus.sursp_rsp   = '0;
    bus.sursp_data  = '0;
  endtask

  // exp_lat < 0 skips the latency check; lat counts edges after the cdreq handshake.
  task automatic expect_rsp(input string tag, input int exp_lat, input logic [1:0] rsp,
                            input logic [31:0] data, input bit no_sd);
    int lat = 0;
    bit sd_seen = 1'b0;
    while (!bus.cursp_valid && lat < 40) begin
      if (bus.sdreq_valid) sd_seen = 1'b1;
      tick();
      lat++;
    end
    chk({tag, "_cursp_valid"}, 64'(bus.cursp_valid), 64'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (no_sd) chk({tag, "_no_sdreq"}, 64'(sd_seen), 64'd0);
    chk({tag, "_cursp_rsp"},  64'(bus.cursp_rsp),  64'(rsp));
    chk({tag, "_cursp_data"}, 64'(bus.cursp_data), 64'(data));
    if (!bus.cursp_ready) begin
      tick();
      tick();
      chk({tag, "_stall_valid"}, 64'(bus.cursp_valid), 64'd1);
      chk({tag, "_stall_data"},  64'(bus.cursp_data),  64'(data));
      bus.cursp_ready = 1'b1;
    end
    tick();
    chk({tag, "_idle"}, 64'(bus.cdreq_ready), 64'd1);
  endtask

  initial begin
    bus.cdreq_valid = 1'b0;
    bus.cdreq_op    = '0;
    bus.cdreq_addr  = '0;
    bus.cdreq_data  = '0;
    bus.cursp_ready = 1'b1;
    bus.sdreq_ready = 1'b0;
    bus.sursp_valid = 1'b0;
    bus.sursp_rsp   = '0;
    bus.sursp_data  = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cdreq_ready", 64'(bus.cdreq_ready), 64'd1);
    chk("rst_cursp_valid", 64'(bus.cursp_valid), 64'd0);
    chk("rst_cursp_data",  64'(bus.cursp_data),  64'd0);
    chk("rst_sdreq_valid", 64'(bus.sdreq_valid), 64'd0);
    chk("rst_sursp_ready", 64'(bus.sursp_ready), 64'd0);
    line_state("rst_line1", 1, MESI_I);

    // Cold read miss fills idx1 EXCLUSIVE.
    send_req("rd15", CDREQ_RD, 8'h15, 32'h0);
    expect_sdreq("rd15", SDREQ_RD, 8'h15, 32'h0);
    send_sursp("rd15", SURSP_FETCH, 32'hDEADBEEF);
    expect_rsp("rd15", -1, CURSP_OKAY, 32'hDEADBEEF, 1'b0);
    line_state("rd15_line1", 1, MESI_E);

    // Read hit, with the core stalling the response.
    bus.cursp_ready = 1'b0;
    send_req("rd15hit", CDREQ_RD, 8'h15, 32'h0);
    expect_rsp("rd15hit", 1, CURSP_OKAY, 32'hDEADBEEF, 1'b1);

    send_req("md15", CDREQ_MD, 8'h15, 32'h12345678);
    expect_rsp("md15", 1, CURSP_OKAY, 32'h0, 1'b1);
    line_state("md15_line1", 1, MESI_M);

    // Conflict miss on a MODIFIED victim: write-back first, then the fill.
    send_req("rd25", CDREQ_RD, 8'h25, 32'h0);
    expect_sdreq("rd25_wb", SDREQ_WB, 8'h15, 32'h12345678);
    send_sursp("rd25_wb", SURSP_OKAY, 32'h0);
    expect_sdreq("rd25_fill", SDREQ_RD, 8'h25, 32'h0);
    send_sursp("rd25_fill", SURSP_FETCH, 32'hCAFEF00D);
    expect_rsp("rd25", -1, CURSP_OKAY, 32'hCAFEF00D, 1'b0);
    line_state("rd25_line1", 1, MESI_E);

    send_req("rd2a", CDREQ_RD, 8'h2A, 32'h0);
    expect_sdreq("rd2a", SDREQ_RD, 8'h2A, 32'h0);
    send_sursp("rd2a", SURSP_SNOOP, 32'h00000077);
    expect_rsp("rd2a", -1, CURSP_OKAY, 32'h00000077, 1'b0);
    line_state("rd2a_line2", 2, MESI_S);

    send_req("md2a", CDREQ_MD, 8'h2A, 32'h5);
    expect_sdreq("md2a", SDREQ_INV, 8'h2A, 32'h0);
    send_sursp("md2a", SURSP_OKAY, 32'h0);
    expect_rsp("md2a", -1, CURSP_OKAY, 32'h0, 1'b0);
    line_state("md2a_line2", 2, MESI_M);

    send_req("rd2ahit", CDREQ_RD, 8'h2A, 32'h0);
    expect_rsp("rd2ahit", 1, CURSP_OKAY, 32'h5, 1'b1);

    send_req("rd33", CDREQ_RD, 8'h33, 32'h0);
    expect_sdreq("rd33", SDREQ_RD, 8'h33, 32'h0);
    send_sursp("rd33", SURSP_ERROR, 32'h99);
    expect_rsp("rd33", -1, CURSP_ERROR, 32'h0, 1'b0);
    line_state("rd33_line3", 3, MESI_I);

    send_req("badop", 3'b111, 8'h25, 32'h0);
    expect_rsp("badop", 1, CURSP_ERROR, 32'h0, 1'b1);
    line_state("badop_line1", 1, MESI_E);

    send_req("wb2a", CDREQ_WB, 8'h2A, 32'h0);
    expect_sdreq("wb2a", SDREQ_WB, 8'h2A, 32'h5);
    send_sursp("wb2a", SURSP_OKAY, 32'h0);
    expect_rsp("wb2a", -1, CURSP_OKAY, 32'h0, 1'b0);
    line_state("wb2a_line2", 2, MESI_E);

    send_req("wbmiss", CDREQ_WB, 8'h33, 32'h0);
    expect_rsp("wbmiss", 1, CURSP_OKAY, 32'h0, 1'b1);

    // Stray bus response while idle must be ignored.
    bus.sursp_valid = 1'b1;
    bus.sursp_rsp   = SURSP_ERROR;
    tick();
    chk("stray_sursp_ready", 64'(bus.sursp_ready), 64'd0);
    send_req("stray_rd25", CDREQ_RD, 8'h25, 32'h0);
    expect_rsp("stray_rd25", 1, CURSP_OKAY, 32'hCAFEF00D, 1'b1);
    bus.sursp_valid = 1'b0;
    bus.sursp_rsp   = '0;

    // Reset while a bus request is outstanding.
    send_req("mid_rst", CDREQ_RD, 8'h11, 32'h0);
    wait_sdvld("mid_rst");
    rst_n = 1'b0;
    tick();
    chk("mid_rst_sdreq_valid", 64'(bus.sdreq_valid), 64'd0);
    chk("mid_rst_cursp_valid", 64'(bus.cursp_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_cdreq_ready", 64'(bus.cdreq_ready), 64'd1);
    line_state("mid_rst_line1", 1, MESI_I);

`ifdef REQ_TIMEOUT_EN
    // WAIT_SURSP entry at the sdreq handshake; timeout response 8 edges later.
    send_req("tmo", CDREQ_RD, 8'h40, 32'h0);
    wait_sdvld("tmo");
    bus.sdreq_ready = 1'b1;
    tick();
    bus.sdreq_ready = 1'b0;
    begin
      int n = 0;
      while (!bus.cursp_valid && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_latency", 64'(n), 64'd8);
    end
    chk("tmo_cursp_rsp", 64'(bus.cursp_rsp), 64'(CURSP_ERROR));
    tick();
    chk("tmo_idle", 64'(bus.cdreq_ready), 64'd1);
    line_state("tmo_line0", 0, MESI_I);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
